// File: rtl/dst_sel_pipe.sv
// Destination-register select plus a DEPTH-stage tracking pipe with stall/flush; 1-cycle capture latency.
// No backpressure: stall holds stage 0 and bubbles stage 1; forwarding is combinational from stage registers only.
module dst_sel_pipe #(
  parameter  int AW        = 5,
  parameter  int DEPTH     = 3,
  parameter  int LINK_ADDR = 31,
  localparam int FW        = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       rt,
  input  logic [AW-1:0]       rd,
  input  logic [1:0]          dst_sel,
  input  logic                wen_in,
  input  logic                valid_in,
  input  logic                stall,
  input  logic                flush,
  input  logic [AW-1:0]       src_a,
  input  logic [AW-1:0]       src_b,
  output logic [DEPTH*AW-1:0] stage_addr,
  output logic [DEPTH-1:0]    stage_wen,
  output logic [FW-1:0]       fwd_a,
  output logic [FW-1:0]       fwd_b
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wen;
  } entry_t;

  localparam entry_t BUBBLE = '{addr: '0, wen: 1'b0};

  entry_t        stage_q [DEPTH];
  entry_t        new_entry;
  logic [AW-1:0] new_addr;

  always_comb begin
    new_addr = '0;
    case (dst_sel)
      2'b00:   new_addr = rt;
      2'b01:   new_addr = rd;
      2'b10:   new_addr = AW'(LINK_ADDR);
      default: new_addr = '0;
    endcase
  end

  // r0 is hard-wired, so a write to it never needs tracking
  always_comb begin
    new_entry.addr = new_addr;
    new_entry.wen  = valid_in & wen_in & (dst_sel != 2'b11) & (new_addr != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= BUBBLE;
    end else begin
      for (int k = 2; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      if (flush) begin
        stage_q[0] <= BUBBLE;
        stage_q[1] <= stall ? BUBBLE : stage_q[0];
      end else if (stall) begin
        stage_q[1] <= BUBBLE;
      end else begin
        stage_q[0] <= new_entry;
        stage_q[1] <= stage_q[0];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_addr[k*AW +: AW] = stage_q[k].addr;
      stage_wen[k]           = stage_q[k].wen;
    end
  end

  // Scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stage_q[k].wen && (stage_q[k].addr == src_a) && (src_a != '0)) fwd_a = FW'(k + 1);
      if (stage_q[k].wen && (stage_q[k].addr == src_b) && (src_b != '0)) fwd_b = FW'(k + 1);
    end
  end

endmodule

// File: tb/tb_dst_sel_pipe.sv
// Directed bench for dst_sel_pipe at AW=5, DEPTH=3, LINK_ADDR=31.
module tb_dst_sel_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rt, rd, src_a, src_b;
  logic [1:0]  dst_sel;
  logic        wen_in, valid_in, stall, flush;
  logic [14:0] stage_addr;
  logic [2:0]  stage_wen;
  logic [1:0]  fwd_a, fwd_b;

  int tests = 0;
  int fails = 0;

  dst_sel_pipe #(.AW(5), .DEPTH(3), .LINK_ADDR(31)) dut (
    .clk(clk), .rst(rst), .rt(rt), .rd(rd), .dst_sel(dst_sel),
    .wen_in(wen_in), .valid_in(valid_in), .stall(stall), .flush(flush),
    .src_a(src_a), .src_b(src_b), .stage_addr(stage_addr),
    .stage_wen(stage_wen), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stages(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                            input logic [4:0] a2, input logic [2:0] w);
    chk({tag, "_addr"}, 32'(stage_addr), 32'({a2, a1, a0}));
    chk({tag, "_wen"},  32'(stage_wen),  32'(w));
  endtask

  task automatic wr_rt(input logic [4:0] a);
    dst_sel = 2'b00; rt = a; wen_in = 1'b1; valid_in = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; rt = '0; rd = '0; dst_sel = 2'b00; wen_in = 1'b0; valid_in = 1'b0;
    stall = 1'b0; flush = 1'b0; src_a = 5'd7; src_b = 5'd12;
    tick(); tick();
    chk_stages("reset", 5'd0, 5'd0, 5'd0, 3'b000);
    chk("reset_fwd_a", 32'(fwd_a), 32'd0);
    chk("reset_fwd_b", 32'(fwd_b), 32'd0);

    rst = 1'b0;
    wr_rt(5'd0);
    chk_stages("r0_write", 5'd0, 5'd0, 5'd0, 3'b000);

    wr_rt(5'd7);
    dst_sel = 2'b01; rd = 5'd12; tick();
    dst_sel = 2'b10; tick();
    chk_stages("sel_modes", 5'd31, 5'd12, 5'd7, 3'b111);
    chk("sel_fwd_a", 32'(fwd_a), 32'd3);
    chk("sel_fwd_b", 32'(fwd_b), 32'd2);

    dst_sel = 2'b11; tick();
    chk_stages("sel_nowrite", 5'd0, 5'd31, 5'd12, 3'b110);

    wr_rt(5'd9); wr_rt(5'd4); wr_rt(5'd9);
    src_a = 5'd9; src_b = 5'd4; #1;
    chk("fwd_youngest", 32'(fwd_a), 32'd1);
    chk("fwd_mid", 32'(fwd_b), 32'd2);

    wr_rt(5'd9); wr_rt(5'd4);
    wen_in = 1'b0; rt = 5'd9; tick();
    chk_stages("fwd_s0_nowen", 5'd9, 5'd4, 5'd9, 3'b110);
    chk("fwd_skip_s0", 32'(fwd_a), 32'd3);
    src_b = 5'd0; #1;
    chk("fwd_src0", 32'(fwd_b), 32'd0);

    wr_rt(5'd7); wr_rt(5'd6); wr_rt(5'd5);
    stall = 1'b1; rt = 5'd20; tick();
    chk_stages("stall", 5'd5, 5'd0, 5'd6, 3'b101);
    stall = 1'b0; tick();
    chk_stages("stall_release", 5'd20, 5'd5, 5'd0, 3'b011);

    wr_rt(5'd7); wr_rt(5'd6); wr_rt(5'd5);
    flush = 1'b1; rt = 5'd20; tick();
    flush = 1'b0;
    chk_stages("flush", 5'd0, 5'd5, 5'd6, 3'b110);

    wr_rt(5'd7); wr_rt(5'd6); wr_rt(5'd5);
    flush = 1'b1; stall = 1'b1; rt = 5'd20; tick();
    flush = 1'b0; stall = 1'b0;
    chk_stages("flush_stall", 5'd0, 5'd0, 5'd6, 3'b100);

    src_a = 5'd3; src_b = 5'd8;
    wr_rt(5'd3); wr_rt(5'd8);
    chk("midrst_pre_fwd_b", 32'(fwd_b), 32'd1);
    rst = 1'b1; rt = 5'd11; tick();
    rst = 1'b0;
    chk_stages("midrst", 5'd0, 5'd0, 5'd0, 3'b000);
    chk("midrst_fwd_a", 32'(fwd_a), 32'd0);
    chk("midrst_fwd_b", 32'(fwd_b), 32'd0);
    tick();
    chk_stages("midrst_resume", 5'd11, 5'd0, 5'd0, 3'b001);
    src_a = 5'd11; #1;
    chk("midrst_resume_fwd", 32'(fwd_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
